// File: rtl/uart_tx_core.sv
// Double-buffered UART transmitter: a holding register feeds a shift register so one
// byte can wait while another is on the wire. Rounded baud divider, optional parity, 1 or 2 stops.
module uart_tx_core #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk_50_mhz,
    input  logic       aresetn,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ovf
);

    localparam longint DIV_L = (longint'(CLK_FREQ) + longint'(BAUD) / 64'sd2) / longint'(BAUD);
    localparam int DIV = int'(DIV_L);
    localparam int CW = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(DIV - 2);
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_core: CLK_FREQ/BAUD must round to at least 2 clocks per bit");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_check
            $error("uart_tx_core: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [7:0] b);
        parity_bit = (^b) ^ PARITY_ODD;
    endfunction

    state_t        state_r;
    logic [CW-1:0] baud_r;
    logic [2:0]    idx_r;
    logic          stop_r;
    logic [7:0]    shift_r;
    logic          par_r;
    logic [7:0]    hold_r;
    logic          hold_valid_r;
    logic          wr_en_q_r;

    logic          write_s;
    logic          baud_wrap_s;
    logic          frame_end_s;
    logic          xfer_s;
    logic          bypass_s;
    logic          accept_s;
    logic          load_s;
    logic [7:0]    load_byte_s;

    // Write detection, accept decision and the byte the shifter loads next.
    // A byte written on the last stop cycle with an empty holder goes straight to the shifter.
    always_comb begin
        write_s     = wr_en & ~wr_en_q_r;
        baud_wrap_s = (baud_r == BAUD_LAST);
        frame_end_s = (state_r == ST_STOP) && baud_wrap_s && (stop_r == STOP_LAST);
        xfer_s      = hold_valid_r && ((state_r == ST_IDLE) || frame_end_s);
        bypass_s    = frame_end_s && !hold_valid_r && write_s;
        accept_s    = write_s && (!hold_valid_r || xfer_s);
        load_s      = xfer_s || bypass_s;
        if (hold_valid_r) begin
            load_byte_s = hold_r;
        end else begin
            load_byte_s = din;
        end
    end

    assign tx_busy = hold_valid_r;

    // Holding register, write edge detector and overrun pulse.
    always_ff @(posedge clk_50_mhz or negedge aresetn) begin
        if (!aresetn) begin
            wr_en_q_r    <= 1'b0;
            hold_r       <= 8'h00;
            hold_valid_r <= 1'b0;
            tx_ovf       <= 1'b0;
        end else begin
            wr_en_q_r <= wr_en;
            tx_ovf    <= write_s && !accept_s;
            if (accept_s && !bypass_s) begin
                hold_r       <= din;
                hold_valid_r <= 1'b1;
            end else if (xfer_s) begin
                hold_valid_r <= 1'b0;
            end else begin
                hold_valid_r <= hold_valid_r;
            end
        end
    end

    // Frame sequencer; tx and tx_done are registered alongside the state.
    always_ff @(posedge clk_50_mhz or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            idx_r   <= 3'd0;
            stop_r  <= 1'b0;
            shift_r <= 8'h00;
            par_r   <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (load_s) begin
                        shift_r <= load_byte_s;
                        par_r   <= parity_bit(load_byte_s);
                        baud_r  <= '0;
                        state_r <= ST_START;
                        tx      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_wrap_s) begin
                        baud_r  <= '0;
                        idx_r   <= 3'd0;
                        state_r <= ST_DATA;
                        tx      <= shift_r[0];
                    end else begin
                        baud_r <= baud_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_wrap_s) begin
                        baud_r <= '0;
                        if (idx_r == 3'd7) begin
                            if (PARITY_EN) begin
                                state_r <= ST_PARITY;
                                tx      <= par_r;
                            end else begin
                                state_r <= ST_STOP;
                                stop_r  <= 1'b0;
                                tx      <= 1'b1;
                            end
                        end else begin
                            idx_r   <= idx_r + 3'd1;
                            shift_r <= shift_r >> 1;
                            tx      <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_wrap_s) begin
                        baud_r  <= '0;
                        stop_r  <= 1'b0;
                        state_r <= ST_STOP;
                        tx      <= 1'b1;
                    end else begin
                        baud_r <= baud_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    tx <= 1'b1;
                    if (baud_wrap_s) begin
                        baud_r <= '0;
                        if (stop_r == STOP_LAST) begin
                            if (load_s) begin
                                shift_r <= load_byte_s;
                                par_r   <= parity_bit(load_byte_s);
                                state_r <= ST_START;
                                tx      <= 1'b0;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            stop_r <= 1'b1;
                        end
                    end else begin
                        baud_r  <= baud_r + CW'(1);
                        // raise done so it coincides with the very last stop cycle
                        tx_done <= (stop_r == STOP_LAST) && (baud_r == BAUD_PRE);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: three instances (DIV=16 plain, DIV=16 odd parity + 2 stops, default 434)
// checked every cycle against a frame-level model, plus literal timing/frame expectations.
module tb_uart_tx_core;

    logic       clk;
    logic [2:0] rn;
    logic [2:0] we;
    logic [7:0] dd [3];
    logic [2:0] tx_o, busy_o, done_o, ovf_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_tx_core #(.CLK_FREQ(16), .BAUD(1)) u_d0 (
        .clk_50_mhz(clk), .aresetn(rn[0]), .din(dd[0]), .wr_en(we[0]),
        .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]), .tx_ovf(ovf_o[0]));

    uart_tx_core #(.CLK_FREQ(16), .BAUD(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) u_d1 (
        .clk_50_mhz(clk), .aresetn(rn[1]), .din(dd[1]), .wr_en(we[1]),
        .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]), .tx_ovf(ovf_o[1]));

    uart_tx_core u_d2 (
        .clk_50_mhz(clk), .aresetn(rn[2]), .din(dd[2]), .wr_en(we[2]),
        .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]), .tx_ovf(ovf_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance parameters as seen by the model
    int p_div [3]  = '{16, 16, 434};
    int p_pen [3]  = '{0, 1, 0};
    int p_odd [3]  = '{0, 1, 0};
    int p_stop [3] = '{1, 2, 1};

    // frame-level model: one byte on the line, at most one byte pending
    bit         m_act [3]  = '{0, 0, 0};
    int         m_cyc [3]  = '{0, 0, 0};
    logic [7:0] m_byte [3] = '{8'h00, 8'h00, 8'h00};
    bit         m_pv [3]   = '{0, 0, 0};
    logic [7:0] m_pend [3] = '{8'h00, 8'h00, 8'h00};
    bit         m_ovf [3]  = '{0, 0, 0};
    bit         m_prev [3] = '{0, 0, 0};

    // observation of the real line
    bit         in_fr [3]     = '{0, 0, 0};
    bit         meas [3]      = '{0, 0, 0};
    bit         prev_tx [3]   = '{1, 1, 1};
    int         fall [3]      = '{0, 0, 0};
    int         run [3]       = '{0, 0, 0};
    int         start_len [3] = '{0, 0, 0};
    int         frame_len [3] = '{0, 0, 0};
    logic [11:0] cap_v [3]    = '{12'h000, 12'h000, 12'h000};
    int         done_cnt [3]  = '{0, 0, 0};
    int         last_done [3] = '{0, 0, 0};
    int         prev_done [3] = '{0, 0, 0};
    int         ovf_cnt [3]   = '{0, 0, 0};
    int         rx_q [$];

    function automatic int frame_clks(input int i);
        return (9 + p_pen[i] + p_stop[i]) * p_div[i];
    endfunction

    function automatic logic exp_bit(input int i, input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if ((k == 9) && (p_pen[i] != 0)) return (^b) ^ (p_odd[i] != 0);
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h cycle=%0d", name, id, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int i);
        bit rise, last, xfer, took;
        if (!rn[i]) begin
            m_act[i] = 0; m_cyc[i] = 0; m_pv[i] = 0; m_ovf[i] = 0; m_prev[i] = 0;
            return;
        end
        rise = we[i] && !m_prev[i];
        m_prev[i] = we[i];
        m_ovf[i] = 0;
        last = m_act[i] && (m_cyc[i] == frame_clks(i) - 1);
        xfer = m_pv[i] && (!m_act[i] || last);
        took = 0;
        if (m_act[i] && !last) begin
            m_cyc[i]++;
        end else if (xfer) begin
            m_byte[i] = m_pend[i]; m_act[i] = 1; m_cyc[i] = 0; m_pv[i] = 0;
        end else if (last && rise) begin
            m_byte[i] = dd[i]; m_act[i] = 1; m_cyc[i] = 0; took = 1;
        end else begin
            m_act[i] = 0;
        end
        if (rise && !took) begin
            if (m_pv[i]) m_ovf[i] = 1;
            else begin
                m_pend[i] = dd[i];
                m_pv[i] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) model_step(i);
    end

    // per-cycle compare against the model, then line observation
    always @(negedge clk) begin : cmp
        logic e_tx;
        int rel;
        for (int i = 0; i < 3; i++) begin
            if (!rn[i]) begin
                chk("rst_tx", i, tx_o[i], 1);
                chk("rst_busy", i, busy_o[i], 0);
                chk("rst_done", i, done_o[i], 0);
                chk("rst_ovf", i, ovf_o[i], 0);
                in_fr[i] = 0; meas[i] = 0; prev_tx[i] = 1;
            end else begin
                e_tx = m_act[i] ? exp_bit(i, m_byte[i], m_cyc[i] / p_div[i]) : 1'b1;
                chk("tx", i, tx_o[i], e_tx);
                chk("busy", i, busy_o[i], m_pv[i]);
                chk("done", i, done_o[i], m_act[i] && (m_cyc[i] == frame_clks(i) - 1));
                chk("ovf", i, ovf_o[i], m_ovf[i]);
                if (!in_fr[i] && prev_tx[i] && !tx_o[i]) begin
                    in_fr[i] = 1; fall[i] = cyc; run[i] = 0; meas[i] = 1; cap_v[i] = 12'h000;
                end
                if (in_fr[i]) begin
                    rel = cyc - fall[i];
                    if (meas[i]) begin
                        if (!tx_o[i]) run[i]++;
                        else begin
                            meas[i] = 0;
                            start_len[i] = run[i];
                        end
                    end
                    if ((rel % p_div[i] == p_div[i] / 2) && (rel / p_div[i] < 12))
                        cap_v[i][rel / p_div[i]] = tx_o[i];
                    if (done_o[i]) begin
                        frame_len[i] = rel + 1;
                        in_fr[i] = 0;
                        rx_q.push_back(i * 4096 + int'(cap_v[i]));
                    end
                end
                if (done_o[i]) begin
                    done_cnt[i]++;
                    prev_done[i] = last_done[i];
                    last_done[i] = cyc;
                end
                if (ovf_o[i]) ovf_cnt[i]++;
                prev_tx[i] = tx_o[i];
            end
        end
    end

    task automatic write_byte(input int i, input logic [7:0] b);
        @(posedge clk); #2;
        dd[i] = b;
        we[i] = 1'b1;
        repeat (4) @(posedge clk);
        #2 we[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int target, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(posedge clk);
            if (done_cnt[i] >= target) break;
        end
        if (n >= budget) begin
            checks++; failures++;
            $display("FAIL wait_done[%0d] actual=%0d expected=%0d dones", i, done_cnt[i], target);
        end
    endtask

    task automatic wait_rel(input int i, input int clks);
        int n;
        for (n = 0; n < 600; n++) begin
            @(negedge clk);
            if (in_fr[i] && (cyc - fall[i] >= clks)) break;
        end
        if (n >= 600) begin
            checks++; failures++;
            $display("FAIL wait_rel[%0d] actual=no_frame expected=in_frame", i);
        end
    endtask

    task automatic check_frame(input string name, input int id, input logic [11:0] exp, input logic [11:0] mask);
        int v;
        if (rx_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s[%0d] actual=none expected=%0h", name, id, exp);
        end else begin
            v = rx_q.pop_front();
            chk({name, "_id"}, id, v / 4096, id);
            chk(name, id, (v % 4096) & int'(mask), exp & mask);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base, obase;
        rn = 3'b000; we = 3'b000;
        dd[0] = 8'h00; dd[1] = 8'h00; dd[2] = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("reset_tx", i, tx_o[i], 1);
            chk("reset_busy", i, busy_o[i], 0);
        end
        rn = 3'b111;
        repeat (3) @(posedge clk);

        // single frame 0xA5
        write_byte(0, 8'hA5);
        wait_done(0, 1, 400);
        chk("t1_len", 0, frame_len[0], 160);
        chk("t1_start", 0, start_len[0], 16);
        check_frame("t1_frame", 0, 12'h34A, 12'h3FF);
        chk("t1_ovf", 0, ovf_cnt[0], 0);

        // back-to-back, second write while first is in DATA
        repeat (20) @(posedge clk);
        base = done_cnt[0];
        write_byte(0, 8'h55);
        wait_rel(0, 40);
        write_byte(0, 8'h0F);
        chk("t2_busy", 0, busy_o[0], 1);
        wait_done(0, base + 2, 500);
        chk("t2_spacing", 0, last_done[0] - prev_done[0], 160);
        chk("t2_nogap", 0, fall[0] - prev_done[0], 1);
        check_frame("t2_first", 0, 12'h2AA, 12'h3FF);
        check_frame("t2_second", 0, 12'h21E, 12'h3FF);

        // overrun on the third of three quick writes
        repeat (20) @(posedge clk);
        base = done_cnt[0];
        obase = ovf_cnt[0];
        write_byte(0, 8'h01);
        write_byte(0, 8'h02);
        write_byte(0, 8'h03);
        wait_done(0, base + 2, 600);
        repeat (300) @(posedge clk);
        chk("t3_dones", 0, done_cnt[0] - base, 2);
        chk("t3_ovf", 0, ovf_cnt[0] - obase, 1);
        check_frame("t3_first", 0, 12'h202, 12'h3FF);
        check_frame("t3_second", 0, 12'h204, 12'h3FF);
        chk("t3_extra", 0, rx_q.size(), 0);

        // reset in the middle of 0xFF, then a clean 0x3C
        repeat (20) @(posedge clk);
        write_byte(0, 8'hFF);
        wait_rel(0, 50);
        base = done_cnt[0];
        @(posedge clk); #2;
        rn[0] = 1'b0;
        #1;
        chk("t5_tx_now", 0, tx_o[0], 1);
        chk("t5_busy", 0, busy_o[0], 0);
        repeat (5) @(posedge clk);
        #1 chk("t5_no_done", 0, done_cnt[0] - base, 0);
        @(posedge clk); #2 rn[0] = 1'b1;
        repeat (30) @(posedge clk);
        chk("t5_idle", 0, tx_o[0], 1);
        write_byte(0, 8'h3C);
        wait_done(0, base + 1, 400);
        chk("t5_len", 0, frame_len[0], 160);
        check_frame("t5_frame", 0, 12'h278, 12'h3FF);

        // odd parity, two stop bits
        write_byte(1, 8'h07);
        wait_done(1, 1, 400);
        chk("t4_len", 1, frame_len[1], 192);
        check_frame("t4_frame", 1, 12'hC0E, 12'hFFF);
        chk("t4_ovf", 1, ovf_cnt[1], 0);

        // default divider
        write_byte(2, 8'h41);
        wait_done(2, 1, 5000);
        chk("t6_start", 2, start_len[2], 434);
        chk("t6_len", 2, frame_len[2], 4340);
        check_frame("t6_frame", 2, 12'h282, 12'h3FF);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
